uart_baud_gen: RTL and testbench
================================

# uart_baud_gen

Parametrised baud-tick generator for the UART transmitter and receiver. It replaces the single-output divided clock with single-cycle enable pulses at the oversampling rate, at mid-bit and at bit rate, and keeps a square-wave output for legacy users. A fractional accumulator gives accurate rates from non-integer divisors. Divisor changes are glitch-free, and a restart input lets the receiver phase-align ticks to a start-bit edge.

## Interface
- `CNT_W`, default 27: width of the integer divisor and the cycle counter.
- `FRAC_W`, default 4: width of the fractional divisor. Fraction unit is 1/2^FRAC_W cycle.
- `OVS`, default 16: oversampling ticks per bit. Power of two, ≥ 4.
- `DEF_DIV`, default 26: reset value of the integer shadow divisor.
- `DEF_FRAC`, default 2: reset value of the fractional shadow divisor. With `DEF_DIV`, this gives 27.125 cycles per tick, which is 115200 baud ×16 at 50 MHz.

- `clock_in`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: count enable. When low, all counters hold.
- `restart`  in  1: synchronous phase restart and divisor reload. Has priority over `en`.
- `baud_div`  in  CNT_W: integer part of the oversample period minus 1.
- `baud_frac`  in  FRAC_W: fractional part of the oversample period.
- `tick_ovs`  out  1: one-cycle pulse at OVS × baud.
- `tick_mid`  out  1: one-cycle pulse at the middle of each bit.
- `tick_baud`  out  1: one-cycle pulse at the end of each bit.
- `clock_out`  out  1: square wave that toggles on every `tick_baud`.

## Operation
- Internal state:
  - shadow registers `div_sh` and `frac_sh`
  - cycle counter `cnt` (CNT_W bits)
  - fractional accumulator `acc` (FRAC_W bits)
  - oversample counter `ovs_cnt` (log2(OVS) bits)
- Reset values:
  - `cnt`, `acc`, `ovs_cnt`, `clock_out` and all ticks are 0.
  - `div_sh` = DEF_DIV, `frac_sh` = DEF_FRAC.
- Period limit: `lim` = `div_sh` + `carry`. `carry` is the overflow of `acc` + `frac_sh` and is evaluated when `cnt` == `lim`.
- On an enabled cycle:
  - If `cnt` < `lim`, increment `cnt`.
  - If `cnt` == `lim`:
    - `cnt` ← 0.
    - `acc` ← (`acc` + `frac_sh`) mod 2^FRAC_W.
    - `tick_ovs` pulses.
    - `ovs_cnt` increments and wraps from OVS-1 to 0.
- `tick_mid` pulses with the `tick_ovs` that moves `ovs_cnt` from OVS/2-1 to OVS/2.
- `tick_baud` pulses with the `tick_ovs` that wraps `ovs_cnt` to 0. In the same cycle, `clock_out` toggles and `div_sh`/`frac_sh` load from `baud_div`/`baud_frac`. Divisor changes therefore take effect only at bit boundaries.
- `restart`:
  - Clears `cnt`, `acc` and `ovs_cnt`.
  - Loads the shadow registers from the ports.
  - Holds all ticks low that cycle. `clock_out` is unchanged.
- `en` low: all state holds and all ticks are 0. A partial period resumes exactly where it stopped.
- `baud_div` = 0 with `frac_sh` = 0: `tick_ovs` is high on every enabled cycle. This is legal.
- Average oversample period: `div_sh` + 1 + `frac_sh`/2^FRAC_W cycles. Over 2^FRAC_W ticks the error is 0 cycles.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- First `tick_ovs` after `restart`: it is sampled at edge 0, and `tick_ovs` is high in the cycle after edge `div`+1 (frac = 0). Latency is `div`+1 enabled cycles.
- Carry-extended periods are exactly 1 cycle longer.
- `tick_ovs`, `tick_mid` and `tick_baud` are each high for exactly 1 cycle.
- `tick_baud` and `tick_mid` are never high together.
- Asserting `rst` mid-period forces all outputs to their reset values immediately, without waiting for the clock.
- `restart` and `en` in the same cycle: `restart` wins.
- A port divisor change without `restart` is invisible until the next `tick_baud`.

## Structure
- `uart_pkg` holds:
  - constants `UART_CNT_W`, `UART_FRAC_W`, `UART_OVS`
  - default divisor constants for 9600 and 115200 baud at 50 MHz
- Parameter defaults come from `uart_pkg`.
- One sub-module, `uart_frac_div`: shadow registers, `cnt`, `acc` and `tick_ovs` generation.
- The top level adds `ovs_cnt`, `tick_mid`, `tick_baud` and `clock_out`.

## Test plan
- Reset, then `restart` with div=26, frac=2:
  - Over 16 `tick_ovs` periods there are 14 gaps of 27 cycles and 2 gaps of 28 cycles, 434 cycles in total.
  - `tick_baud` pulses once per 434 cycles.
  - `clock_out` period is 868 cycles.
- div=0, frac=0: `tick_ovs` is high continuously. `tick_mid` pulses at `ovs_cnt` 7→8 and `tick_baud` at 15→0, each 8 cycles apart.
- Change `baud_div` from 26 to 3 mid-bit without `restart`: the old 27-cycle period holds until `tick_baud`, then the period is 4 cycles.
- Drop `en` for 10 cycles at `cnt`=5 (div=9): no ticks occur, and the next `tick_ovs` arrives 5 enabled cycles after `en` returns.
- Pulse `restart` at `ovs_cnt`=11: the next `tick_mid` comes 8 oversample periods later, and `clock_out` is unchanged.
- Assert `rst` asynchronously between clock edges during `tick_baud`: all ticks and `clock_out` go to 0 before the next edge, and the shadows return to 26/2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART baud-tick generator.
// Divisor defaults are for a 50 MHz system clock with 16x oversampling.
package uart_pkg;

  localparam int UART_CNT_W  = 27;
  localparam int UART_FRAC_W = 4;
  localparam int UART_OVS    = 16;

  // 50e6 / (115200*16) = 27.127 -> 26 + 2/16
  localparam int UART_DIV_115200  = 26;
  localparam int UART_FRAC_115200 = 2;
  // 50e6 / (9600*16) = 325.52 -> 324 + 8/16
  localparam int UART_DIV_9600    = 324;
  localparam int UART_FRAC_9600   = 8;

  typedef struct packed {
    logic mid;
    logic baud;
  } uart_bit_ticks_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between a UART and its baud-tick generator.
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int CNT_W  = UART_CNT_W,
  parameter int FRAC_W = UART_FRAC_W
);
  logic              en;
  logic              restart;
  logic [CNT_W-1:0]  baud_div;
  logic [FRAC_W-1:0] baud_frac;
  logic              tick_ovs;
  logic              tick_mid;
  logic              tick_baud;
  logic              clock_out;

  modport master (
    output en, restart, baud_div, baud_frac,
    input  tick_ovs, tick_mid, tick_baud, clock_out
  );

  modport slave (
    input  en, restart, baud_div, baud_frac,
    output tick_ovs, tick_mid, tick_baud, clock_out
  );
endinterface

// File: rtl/uart_frac_div.sv
// Fractional cycle divider: shadowed divisor, cycle counter and phase accumulator.
// Emits a registered pulse once per (div_sh + 1 + frac_sh/2^FRAC_W) cycles on average.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int          CNT_W    = UART_CNT_W,
  parameter int          FRAC_W   = UART_FRAC_W,
  parameter int unsigned DEF_DIV  = UART_DIV_115200,
  parameter int unsigned DEF_FRAC = UART_FRAC_115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              load,
  input  logic [CNT_W-1:0]  baud_div,
  input  logic [FRAC_W-1:0] baud_frac,
  output logic              period_end,
  output logic              tick_ovs
);

  logic [CNT_W-1:0]  div_sh_q,  div_sh_d;
  logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [FRAC_W-1:0] acc_q,     acc_d;
  logic              tick_q,    tick_d;

  logic [FRAC_W:0]   acc_sum;
  logic [CNT_W:0]    lim;

  // Carry only changes at period ends, so the limit is stable across a period.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_sh_q};
  assign lim     = {1'b0, div_sh_q} + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};

  assign period_end = en && !restart && ({1'b0, cnt_q} >= lim);

  always_comb begin
    div_sh_d  = div_sh_q;
    frac_sh_d = frac_sh_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    tick_d    = 1'b0;
    if (restart) begin
      cnt_d     = '0;
      acc_d     = '0;
      div_sh_d  = baud_div;
      frac_sh_d = baud_frac;
    end else if (en) begin
      if (period_end) begin
        cnt_d  = '0;
        acc_d  = acc_sum[FRAC_W-1:0];
        tick_d = 1'b1;
        if (load) begin
          div_sh_d  = baud_div;
          frac_sh_d = baud_frac;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_sh_q  <= CNT_W'(DEF_DIV);
      frac_sh_q <= FRAC_W'(DEF_FRAC);
      cnt_q     <= '0;
      acc_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_sh_q  <= div_sh_d;
      frac_sh_q <= frac_sh_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tick_q    <= tick_d;
    end
  end

  assign tick_ovs = tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-tick generator: oversample, mid-bit and end-of-bit enable pulses plus a
// legacy square wave. Divisor updates are applied only at bit boundaries.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int          CNT_W    = UART_CNT_W,
  parameter int          FRAC_W   = UART_FRAC_W,
  parameter int          OVS      = UART_OVS,
  parameter int unsigned DEF_DIV  = UART_DIV_115200,
  parameter int unsigned DEF_FRAC = UART_FRAC_115200
) (
  input  logic             clock_in,
  input  logic             rst,
  uart_baud_gen_if.slave   bus
);

  localparam int OVS_W = $clog2(OVS);

  generate
    if (OVS < 4 || (1 << OVS_W) != OVS) begin : g_bad_ovs
      $error("uart_baud_gen: OVS must be a power of two >= 4");
    end
  endgenerate

  logic             period_end;
  logic             bit_end;
  logic             tick_ovs;

  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  uart_bit_ticks_t  ticks_q,   ticks_d;
  logic             clk_out_q, clk_out_d;

  // The shadow reload must happen on the same edge that wraps ovs_cnt.
  assign bit_end = period_end && (ovs_cnt_q == OVS_W'(OVS - 1));

  uart_frac_div #(
    .CNT_W    (CNT_W),
    .FRAC_W   (FRAC_W),
    .DEF_DIV  (DEF_DIV),
    .DEF_FRAC (DEF_FRAC)
  ) u_frac_div (
    .clk        (clock_in),
    .rst        (rst),
    .en         (bus.en),
    .restart    (bus.restart),
    .load       (bit_end),
    .baud_div   (bus.baud_div),
    .baud_frac  (bus.baud_frac),
    .period_end (period_end),
    .tick_ovs   (tick_ovs)
  );

  always_comb begin
    ovs_cnt_d = ovs_cnt_q;
    ticks_d   = '0;
    clk_out_d = clk_out_q;
    if (bus.restart) begin
      ovs_cnt_d = '0;
    end else if (period_end) begin
      ovs_cnt_d    = ovs_cnt_q + 1'b1;
      ticks_d.mid  = (ovs_cnt_q == OVS_W'(OVS / 2 - 1));
      ticks_d.baud = bit_end;
      if (bit_end) clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      ovs_cnt_q <= '0;
      ticks_q   <= '0;
      clk_out_q <= 1'b0;
    end else begin
      ovs_cnt_q <= ovs_cnt_d;
      ticks_q   <= ticks_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign bus.tick_ovs  = tick_ovs;
  assign bus.tick_mid  = ticks_q.mid;
  assign bus.tick_baud = ticks_q.baud;
  assign bus.clock_out = clk_out_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench: a tick-schedule model predicts every tick; a monitor checks them.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int CW  = UART_CNT_W;
  localparam int FW  = UART_FRAC_W;
  localparam int OVS = UART_OVS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_baud_gen_if #(.CNT_W(CW), .FRAC_W(FW)) bus();

  uart_baud_gen #(
    .CNT_W(CW), .FRAC_W(FW), .OVS(OVS), .DEF_DIV(26), .DEF_FRAC(2)
  ) dut (
    .clock_in (clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    int cyc;
    bit mid;
    bit baud;
    bit clko;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: ticks are scheduled on a timeline of enabled edges.
  int   en_edges, due, acc_m, idx_m, div_m, frac_m;
  bit   clk_m;
  int   last_baud = -1;
  int   exp_gap   = 0;

  task automatic chk(string nm, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int plen(int d, int a, int f);
    return d + 1 + (((a + f) >= (1 << FW)) ? 1 : 0);
  endfunction

  task automatic m_reset();
    en_edges = 0; acc_m = 0; idx_m = 0; clk_m = 0;
    div_m = 26; frac_m = 2;
    due = plen(div_m, acc_m, frac_m);
  endtask

  task automatic model_edge();
    exp_t e;
    cyc++;
    if (rst) m_reset();
    else if (bus.restart) begin
      div_m  = int'(bus.baud_div);
      frac_m = int'(bus.baud_frac);
      acc_m  = 0;
      idx_m  = 0;
      due    = en_edges + plen(div_m, acc_m, frac_m);
    end else if (bus.en) begin
      en_edges++;
      if (en_edges == due) begin
        acc_m = (acc_m + frac_m) % (1 << FW);
        idx_m = (idx_m + 1) % OVS;
        e.cyc  = cyc;
        e.mid  = (idx_m == OVS / 2);
        e.baud = (idx_m == 0);
        if (e.baud) begin
          clk_m  = ~clk_m;
          div_m  = int'(bus.baud_div);
          frac_m = int'(bus.baud_frac);
        end
        e.clko = clk_m;
        q.push_back(e);
        due = en_edges + plen(div_m, acc_m, frac_m);
      end
    end
  endtask

  // Runs n clock edges; returns 1 time unit after the last edge.
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic do_restart(int d, int f);
    bus.baud_div  = CW'(d);
    bus.baud_frac = FW'(f);
    bus.restart   = 1'b1;
    last_baud     = -1;
    tick(1);
    bus.restart   = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.tick_ovs || bus.tick_mid || bus.tick_baud)) begin
      if (q.size() == 0) chk("unexpected_tick", cyc, -1);
      else begin
        e = q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_ovs", bus.tick_ovs, 1);
        chk("tick_mid", bus.tick_mid, e.mid);
        chk("tick_baud", bus.tick_baud, e.baud);
        chk("clock_out", bus.clock_out, e.clko);
        chk("mid_baud_excl", bus.tick_mid && bus.tick_baud, 0);
        if (bus.tick_baud) begin
          if (exp_gap != 0 && last_baud >= 0) chk("baud_gap", cyc - last_baud, exp_gap);
          last_baud = cyc;
        end
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    bus.en = 1'b0; bus.restart = 1'b0;
    bus.baud_div = '0; bus.baud_frac = '0;
    m_reset();
    tick(3);
    chk("rst_tick_ovs",  bus.tick_ovs,  0);
    chk("rst_tick_mid",  bus.tick_mid,  0);
    chk("rst_tick_baud", bus.tick_baud, 0);
    chk("rst_clock_out", bus.clock_out, 0);
    rst = 1'b0;
    tick(2);

    // 115200 baud: 14x27 + 2x28 = 434 cycles per bit
    bus.en = 1'b1;
    exp_gap = 434;
    do_restart(26, 2);
    tick(2000);

    // Maximum rate: tick every cycle, bit every 16
    exp_gap = 16;
    do_restart(0, 0);
    tick(100);

    // Mid-bit divisor change applies only after the next tick_baud
    exp_gap = 0;
    do_restart(26, 0);
    tick(100);
    bus.baud_div = CW'(3);
    tick(600);

    // Enable pause at cnt=5 with div=9
    do_restart(9, 0);
    tick(5);
    bus.en = 1'b0;
    tick(10);
    bus.en = 1'b1;
    tick(50);

    // Restart at ovs_cnt=11 leaves clock_out alone
    do_restart(2, 0);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1);
      if (idx_m == 11) found = 1;
    end
    chk("reach_ovs11", found, 1);
    do_restart(2, 0);
    chk("restart_clock_out", bus.clock_out, clk_m);
    tick(200);

    // Randomized enables, restarts and divisor changes
    for (int i = 0; i < 3000; i++) begin
      bus.en      = ($urandom % 10) != 0;
      bus.restart = ($urandom % 64) == 0;
      if (($urandom % 16) == 0) begin
        bus.baud_div  = CW'($urandom_range(0, 12));
        bus.baud_frac = FW'($urandom % 16);
      end
      tick(1);
    end
    bus.restart = 1'b0;
    bus.en      = 1'b1;

    // Async reset while tick_baud and clock_out are high
    do_restart(1, 0);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick(1);
      if (bus.tick_baud && bus.clock_out) found = 1;
    end
    chk("baud_seen", found, 1);
    #6;
    rst = 1'b1;
    #1;
    chk("arst_tick_ovs",  bus.tick_ovs,  0);
    chk("arst_tick_mid",  bus.tick_mid,  0);
    chk("arst_tick_baud", bus.tick_baud, 0);
    chk("arst_clock_out", bus.clock_out, 0);
    m_reset();
    #1;
    rst = 1'b0;
    // Ports differ from the defaults; the first bit must still run at 26/2
    bus.baud_div  = CW'(5);
    bus.baud_frac = FW'(0);
    last_baud = -1;
    tick(800);

    tick(2);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
